// File: rtl/fp_pkg.sv
// Shared definitions for the sequential floating-point adder/subtractor:
// FSM states, flag positions, field helpers and special-value encodings.
package fp_pkg;

   typedef enum logic [2:0] {
      IDLE,
      UNPACK,
      ALIGN,
      ADD,
      NORM_ROUND,
      DONE
   } state_t;

   localparam int FLAG_INVALID   = 3;
   localparam int FLAG_OVERFLOW  = 2;
   localparam int FLAG_UNDERFLOW = 1;
   localparam int FLAG_INEXACT   = 0;

   // Helpers work on a 64-bit container so any word up to 63 bits fits.
   function automatic logic [63:0] low_mask(input int width);
      return (64'd1 << width) - 64'd1;
   endfunction

   function automatic logic get_sign(input logic [63:0] word, input int exp_w, input int man_w);
      return |((word >> (exp_w + man_w)) & 64'd1);
   endfunction

   function automatic logic [63:0] get_exp(input logic [63:0] word, input int exp_w, input int man_w);
      return (word >> man_w) & low_mask(exp_w);
   endfunction

   function automatic logic [63:0] get_man(input logic [63:0] word, input int man_w);
      return word & low_mask(man_w);
   endfunction

   function automatic logic [63:0] qnan_word(input int exp_w, input int man_w);
      return (low_mask(exp_w) << man_w) | (64'd1 << (man_w - 1));
   endfunction

   function automatic logic [63:0] inf_word(input logic sign, input int exp_w, input int man_w);
      return ({63'd0, sign} << (exp_w + man_w)) | (low_mask(exp_w) << man_w);
   endfunction

   function automatic logic [63:0] zero_word(input logic sign, input int exp_w, input int man_w);
      return {63'd0, sign} << (exp_w + man_w);
   endfunction

endpackage

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter; an all-zero input yields WIDTH.
module fp_lzc
   import fp_pkg::*;
#(
   parameter int WIDTH = 27
) (
   input  logic [WIDTH-1:0]               value,
   output logic [$clog2(WIDTH+1)-1:0]     count
);

   logic found;

   always_comb begin
      count = '0;
      found = 1'b0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (!found) begin
            if (value[i]) found = 1'b1;
            else          count = count + 1'b1;
         end
      end
   end

endmodule

// File: rtl/fp_addsub_seq.sv
// Multi-cycle IEEE-754-style adder/subtractor with round-to-nearest-even,
// special-value handling and a load / ready / ack handshake.
module fp_addsub_seq
   import fp_pkg::*;
#(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     load,
   input  logic                     op_sub,
   input  logic [EXP_W+MAN_W:0]     a,
   input  logic [EXP_W+MAN_W:0]     b,
   output logic [EXP_W+MAN_W:0]     result,
   output logic                     result_ready,
   input  logic                     result_ack,
   output logic                     busy,
   output logic [3:0]               flags
);

   localparam int W   = 1 + EXP_W + MAN_W;
   localparam int EXT = MAN_W + 4;
   localparam int LZW = $clog2(EXT + 1);
   localparam logic [EXP_W-1:0] EXP_ONES = '1;
   localparam logic [W-1:0]     QNAN     = W'(qnan_word(EXP_W, MAN_W));

   state_t state, next_state;

   logic [W-1:0]     a_q, b_q;
   logic             sub_q;
   logic             big_sign, small_sign;
   logic [EXP_W-1:0] big_exp, small_exp;
   logic [MAN_W:0]   big_man, small_man;
   logic             spec_valid;
   logic [W-1:0]     spec_result;
   logic [3:0]       spec_flags;
   logic [EXT-1:0]   big_ext, small_ext;
   logic [EXT:0]     sum_q;

   logic             sa, sb;
   logic [EXP_W-1:0] ea, eb;
   logic [MAN_W-1:0] fa, fb;
   logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_bigger;
   logic             u_spec;
   logic [W-1:0]     u_spec_result;
   logic [3:0]       u_spec_flags;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:       if (load) next_state = UNPACK;
         UNPACK:     next_state = ALIGN;
         ALIGN:      next_state = ADD;
         ADD:        next_state = NORM_ROUND;
         NORM_ROUND: next_state = DONE;
         DONE:       if (result_ready && result_ack) next_state = IDLE;
         default:    next_state = IDLE;
      endcase
   end

   assign busy = (state != IDLE);

   // Classify operands and resolve specials up front so the arithmetic path only sees normals.
   always_comb begin
      sa = get_sign(64'(a_q), EXP_W, MAN_W);
      sb = get_sign(64'(b_q), EXP_W, MAN_W) ^ sub_q;
      ea = EXP_W'(get_exp(64'(a_q), EXP_W, MAN_W));
      eb = EXP_W'(get_exp(64'(b_q), EXP_W, MAN_W));
      fa = MAN_W'(get_man(64'(a_q), MAN_W));
      fb = MAN_W'(get_man(64'(b_q), MAN_W));
      a_zero   = (ea == '0);
      b_zero   = (eb == '0);
      a_inf    = (ea == EXP_ONES) && (fa == '0);
      b_inf    = (eb == EXP_ONES) && (fb == '0);
      a_nan    = (ea == EXP_ONES) && (fa != '0);
      b_nan    = (eb == EXP_ONES) && (fb != '0);
      a_bigger = ({ea, fa} >= {eb, fb});
      u_spec        = 1'b1;
      u_spec_result = '0;
      u_spec_flags  = '0;
      if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) begin
         u_spec_result = QNAN;
         u_spec_flags[FLAG_INVALID] = 1'b1;
      end else if (a_inf) begin
         u_spec_result = W'(inf_word(sa, EXP_W, MAN_W));
      end else if (b_inf) begin
         u_spec_result = W'(inf_word(sb, EXP_W, MAN_W));
      end else if (a_zero && b_zero) begin
         u_spec_result = W'(zero_word(sa & sb, EXP_W, MAN_W));
      end else if (a_zero) begin
         u_spec_result = {sb, b_q[W-2:0]};
      end else if (b_zero) begin
         u_spec_result = a_q;
      end else begin
         u_spec = 1'b0;
      end
   end

   logic [EXP_W-1:0] diff;
   logic [EXT-1:0]   small_full, shifted, small_al;
   logic             lost;

   // Alignment keeps guard/round bits and folds everything shifted out into sticky.
   always_comb begin
      diff       = big_exp - small_exp;
      small_full = {small_man, 3'b000};
      shifted    = small_full >> diff;
      lost       = |(small_full & ~({EXT{1'b1}} << diff));
      if (32'(diff) >= 32'(EXT - 1)) small_al = {{(EXT-1){1'b0}}, |small_man};
      else                           small_al = {shifted[EXT-1:1], shifted[0] | lost};
   end

   logic [EXT:0] sum_c;
   assign sum_c = (big_sign == small_sign) ? ({1'b0, big_ext} + {1'b0, small_ext})
                                           : ({1'b0, big_ext} - {1'b0, small_ext});

   logic [LZW-1:0]     lz_count;
   logic [EXT-1:0]     norm;
   logic signed [31:0] exp_n, exp_r;
   logic [MAN_W+1:0]   rounded;
   logic [MAN_W-1:0]   frac;
   logic               guard, rnd, sticky, round_up;
   logic [W-1:0]       nr_result;
   logic [3:0]         nr_flags;

   fp_lzc #(.WIDTH(EXT)) u_lzc (
      .value (sum_q[EXT-1:0]),
      .count (lz_count)
   );

   // Normalise, round to nearest-even, then clamp to Inf or zero when out of range.
   always_comb begin
      if (sum_q[EXT]) begin
         norm  = {sum_q[EXT:2], sum_q[1] | sum_q[0]};
         exp_n = $signed(32'(big_exp)) + 32'sd1;
      end else begin
         norm  = sum_q[EXT-1:0] << lz_count;
         exp_n = $signed(32'(big_exp)) - $signed(32'(lz_count));
      end
      guard    = norm[2];
      rnd      = norm[1];
      sticky   = norm[0];
      round_up = guard & (rnd | sticky | norm[3]);
      rounded  = {1'b0, norm[EXT-1:3]} + {{(MAN_W+1){1'b0}}, round_up};
      if (rounded[MAN_W+1]) begin
         exp_r = exp_n + 32'sd1;
         frac  = rounded[MAN_W:1];
      end else begin
         exp_r = exp_n;
         frac  = rounded[MAN_W-1:0];
      end
      nr_result = '0;
      nr_flags  = '0;
      if (spec_valid) begin
         nr_result = spec_result;
         nr_flags  = spec_flags;
      end else if (sum_q == '0) begin
         nr_result = W'(zero_word(1'b0, EXP_W, MAN_W));
      end else if (exp_r >= $signed(32'(EXP_ONES))) begin
         nr_result = W'(inf_word(big_sign, EXP_W, MAN_W));
         nr_flags[FLAG_OVERFLOW] = 1'b1;
         nr_flags[FLAG_INEXACT]  = 1'b1;
      end else if (exp_r <= 32'sd0) begin
         nr_result = W'(zero_word(big_sign, EXP_W, MAN_W));
         nr_flags[FLAG_UNDERFLOW] = 1'b1;
         nr_flags[FLAG_INEXACT]   = 1'b1;
      end else begin
         nr_result = {big_sign, exp_r[EXP_W-1:0], frac};
         nr_flags[FLAG_INEXACT] = guard | rnd | sticky;
      end
   end

   // Each FSM state loads only its own stage registers; result_ready rises one cycle into DONE.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         a_q <= '0;  b_q <= '0;  sub_q <= 1'b0;
         big_sign <= 1'b0;  big_exp <= '0;  big_man <= '0;
         small_sign <= 1'b0;  small_exp <= '0;  small_man <= '0;
         spec_valid <= 1'b0;  spec_result <= '0;  spec_flags <= '0;
         big_ext <= '0;  small_ext <= '0;  sum_q <= '0;
         result <= '0;  flags <= '0;  result_ready <= 1'b0;
      end else begin
         case (state)
            IDLE: if (load) begin
               a_q   <= a;
               b_q   <= b;
               sub_q <= op_sub;
            end
            UNPACK: begin
               big_sign    <= a_bigger ? sa : sb;
               big_exp     <= a_bigger ? ea : eb;
               big_man     <= a_bigger ? {~a_zero, fa} : {~b_zero, fb};
               small_sign  <= a_bigger ? sb : sa;
               small_exp   <= a_bigger ? eb : ea;
               small_man   <= a_bigger ? {~b_zero, fb} : {~a_zero, fa};
               spec_valid  <= u_spec;
               spec_result <= u_spec_result;
               spec_flags  <= u_spec_flags;
            end
            ALIGN: begin
               big_ext   <= {big_man, 3'b000};
               small_ext <= small_al;
            end
            ADD: sum_q <= sum_c;
            NORM_ROUND: begin
               result <= nr_result;
               flags  <= nr_flags;
            end
            DONE: begin
               if (!result_ready)   result_ready <= 1'b1;
               else if (result_ack) result_ready <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fp_addsub_seq.sv
// Table-driven, scoreboarded bench for fp_addsub_seq in single precision.
module tb_fp_addsub_seq;

   logic        clk, reset, load, op_sub, result_ack;
   logic [31:0] a, b, result;
   logic        result_ready, busy;
   logic [3:0]  flags;

   typedef struct {
      string       name;
      logic [31:0] a;
      logic [31:0] b;
      logic        sub;
      logic [31:0] res;
      logic [3:0]  flg;
   } vec_t;

   typedef struct packed {
      logic [31:0] res;
      logic [3:0]  flg;
   } exp_t;

   vec_t vecs[$];
   exp_t sb_q[$];
   int   checks   = 0;
   int   failures = 0;

   fp_addsub_seq #(.EXP_W(8), .MAN_W(23)) dut (
      .clk          (clk),
      .reset        (reset),
      .load         (load),
      .op_sub       (op_sub),
      .a            (a),
      .b            (b),
      .result       (result),
      .result_ready (result_ready),
      .result_ack   (result_ack),
      .busy         (busy),
      .flags        (flags)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // Drives one load at the current negedge; returns at the negedge after the load edge.
   task automatic applyStimulus(input logic [31:0] op_a, input logic [31:0] op_b, input logic sub,
                                input logic [31:0] exp_res, input logic [3:0] exp_flg);
      exp_t e;
      a = op_a;
      b = op_b;
      op_sub = sub;
      load = 1'b1;
      e.res = exp_res;
      e.flg = exp_flg;
      sb_q.push_back(e);
      @(negedge clk);
      load = 1'b0;
      a = $urandom;
      b = $urandom;
      op_sub = 1'($urandom_range(0, 1));
   endtask

   task automatic waitResult(input string name, input int start);
      int cycles = start;
      while (result_ready !== 1'b1 && cycles < 20) begin
         @(negedge clk);
         cycles++;
      end
      checkValue({name, " latency"}, 32'(cycles), 32'd5);
   endtask

   task automatic checkOutput(input string name);
      exp_t e;
      if (sb_q.size() == 0) begin
         checks++;
         failures++;
         $display("[TB] FAIL %s scoreboard actual=empty required=entry", name);
      end else begin
         e = sb_q.pop_front();
         checkValue({name, " result"}, result, e.res);
         checkValue({name, " flags"}, 32'(flags), 32'(e.flg));
      end
   endtask

   task automatic ackResult(input string name);
      result_ack = 1'b1;
      @(negedge clk);
      result_ack = 1'b0;
      checkValue({name, " ready drop"}, 32'(result_ready), 32'd0);
      checkValue({name, " idle"}, 32'(busy), 32'd0);
   endtask

   initial begin
      int stable;
      vecs.push_back('{"1+2",        32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4'b0000});
      vecs.push_back('{"pi-pi",      32'h40490FDB, 32'h40490FDB, 1'b1, 32'h00000000, 4'b0000});
      vecs.push_back('{"-0+-0",      32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'b0000});
      vecs.push_back('{"tie even",   32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0001});
      vecs.push_back('{"round up",   32'h3F800000, 32'h33800001, 1'b0, 32'h3F800001, 4'b0001});
      vecs.push_back('{"overflow",   32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b0101});
      vecs.push_back('{"inf-inf",    32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 4'b1000});
      vecs.push_back('{"snan",       32'h7FA00000, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b1000});
      vecs.push_back('{"inf-inf sub",32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 4'b1000});
      vecs.push_back('{"3-1",        32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 4'b0000});
      vecs.push_back('{"1-2",        32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 4'b0000});
      vecs.push_back('{"0-1",        32'h00000000, 32'h3F800000, 1'b1, 32'hBF800000, 4'b0000});
      vecs.push_back('{"denorm+1",   32'h00000001, 32'h3F800000, 1'b0, 32'h3F800000, 4'b0000});
      vecs.push_back('{"inf+1",      32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 4'b0000});
      vecs.push_back('{"1-inf",      32'h3F800000, 32'h7F800000, 1'b1, 32'hFF800000, 4'b0000});
      vecs.push_back('{"underflow",  32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 4'b0011});
      vecs.push_back('{"carry",      32'h3F7FFFFF, 32'h33800000, 1'b0, 32'h3F800000, 4'b0000});
      vecs.push_back('{"rnd ovf",    32'h3F7FFFFF, 32'h33000000, 1'b0, 32'h3F800000, 4'b0001});

      reset = 1'b1;  load = 1'b0;  op_sub = 1'b0;  result_ack = 1'b0;  a = '0;  b = '0;
      repeat (3) @(negedge clk);
      checkValue("reset ready", 32'(result_ready), 32'd0);
      checkValue("reset busy", 32'(busy), 32'd0);
      checkValue("reset result", result, 32'd0);
      checkValue("reset flags", 32'(flags), 32'd0);
      reset = 1'b0;

      foreach (vecs[i]) begin
         applyStimulus(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].res, vecs[i].flg);
         waitResult(vecs[i].name, 0);
         checkOutput(vecs[i].name);
         ackResult(vecs[i].name);
      end

      $display("[TB] handshake sequence");
      applyStimulus(32'h3F800000, 32'h40400000, 1'b0, 32'h40800000, 4'b0000);
      load = 1'b1;  a = 32'h40000000;  b = 32'h40000000;
      @(negedge clk);
      load = 1'b0;
      waitResult("hs", 1);
      checkOutput("hs");
      load = 1'b1;  a = 32'hC0000000;  b = 32'h3F800000;
      @(negedge clk);
      load = 1'b0;
      stable = 0;
      for (int i = 0; i < 10; i++) begin
         if (result_ready === 1'b1 && result === 32'h40800000 && flags === 4'b0000) stable++;
         @(negedge clk);
      end
      checkValue("hs stable", 32'(stable), 32'd10);
      begin
         exp_t e;
         e.res = 32'hBF800000;
         e.flg = 4'b0000;
         sb_q.push_back(e);
      end
      result_ack = 1'b1;  load = 1'b1;  a = 32'hC0000000;  b = 32'h3F800000;  op_sub = 1'b0;
      @(negedge clk);
      result_ack = 1'b0;
      checkValue("hs ack ready", 32'(result_ready), 32'd0);
      checkValue("hs ack idle", 32'(busy), 32'd0);
      @(negedge clk);
      load = 1'b0;  a = $urandom;  b = $urandom;
      checkValue("hs reload busy", 32'(busy), 32'd1);
      waitResult("hs next", 0);
      checkOutput("hs next");
      ackResult("hs next");

      $display("[TB] reset during ADD");
      load = 1'b1;  a = 32'h3F800000;  b = 32'h40000000;  op_sub = 1'b0;
      @(negedge clk);
      load = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      checkValue("mid reset ready", 32'(result_ready), 32'd0);
      checkValue("mid reset busy", 32'(busy), 32'd0);
      checkValue("mid reset result", result, 32'd0);
      checkValue("mid reset flags", 32'(flags), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      applyStimulus(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4'b0000);
      waitResult("after reset", 0);
      checkOutput("after reset");
      ackResult("after reset");
      checkValue("scoreboard drained", 32'(sb_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
